// File: rtl/booth_mac_accum.sv
// Frame accumulator behind the 16x16 Booth multiplier: sums cfg_len signed products
// and presents the frame total, optionally saturated to PROD_W bits, on valid/ready.
module booth_mac_accum #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              sat_en,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [PROD_W-1:0] acc_data,
  output logic              acc_sat,
  output logic [ACC_W-1:0]  acc_raw
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic                valid_q, valid_d;
  logic [PROD_W-1:0]   data_q, data_d;
  logic                flag_q, flag_d;
  logic [ACC_W-1:0]    raw_q, raw_d;

  logic                beat_s;
  logic                take_s;
  logic [ACC_W-1:0]    sext_s;
  logic [ACC_W-1:0]    sum_s;
  logic [ACC_W-1:0]    fin_acc_s;
  logic                fin_en_s;
  logic [PROD_W:0]     fin_res_s;

  // Returns {sat_flag, data}: clamps when the bits above the PROD_W sign bit disagree.
  function automatic logic [PROD_W:0] sat_fn(input logic [ACC_W-1:0] a, input logic en);
    logic [ACC_W-PROD_W:0] upper;
    logic                  ovf;
    upper = a[ACC_W-1:PROD_W-1];
    ovf   = !((&upper) || (~|upper));
    if (en && ovf) begin
      if (a[ACC_W-1]) begin
        sat_fn = {1'b1, 1'b1, {(PROD_W-1){1'b0}}};
      end else begin
        sat_fn = {1'b1, 1'b0, {(PROD_W-1){1'b1}}};
      end
    end else begin
      sat_fn = {1'b0, a[PROD_W-1:0]};
    end
  endfunction

  assign prod_ready = rst_n & ~clear & (state_q != S_OUT);
  assign beat_s     = prod_valid & prod_ready;
  assign take_s     = valid_q & acc_ready;
  assign sext_s     = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
  assign sum_s      = acc_q + sext_s;

  // The final beat may land in IDLE (single-product frame) or in ACCUM.
  assign fin_acc_s  = (state_q == S_IDLE) ? sext_s : sum_s;
  assign fin_en_s   = (state_q == S_IDLE) ? sat_en : sat_q;
  assign fin_res_s  = sat_fn(fin_acc_s, fin_en_s);

  assign acc_valid  = valid_q;
  assign acc_data   = data_q;
  assign acc_sat    = flag_q;
  assign acc_raw    = raw_q;

  // Next-state and next-output logic for the IDLE/ACCUM/OUT frame sequencer.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    data_d  = data_q;
    flag_d  = flag_q;
    raw_d   = raw_q;
    if (clear) begin
      state_d = S_IDLE;
      acc_d   = {ACC_W{1'b0}};
      cnt_d   = {LEN_W{1'b0}};
      valid_d = 1'b0;
      data_d  = {PROD_W{1'b0}};
      flag_d  = 1'b0;
      raw_d   = {ACC_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (beat_s) begin
            acc_d = sext_s;
            sat_d = sat_en;
            cnt_d = cfg_len - LEN_W'(1);
            if (cfg_len == LEN_W'(1)) begin
              state_d = S_OUT;
              valid_d = 1'b1;
              flag_d  = fin_res_s[PROD_W];
              data_d  = fin_res_s[PROD_W-1:0];
              raw_d   = fin_acc_s;
            end else begin
              state_d = S_ACCUM;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ACCUM: begin
          if (beat_s) begin
            acc_d = sum_s;
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_d = S_OUT;
              valid_d = 1'b1;
              flag_d  = fin_res_s[PROD_W];
              data_d  = fin_res_s[PROD_W-1:0];
              raw_d   = fin_acc_s;
            end else begin
              state_d = S_ACCUM;
            end
          end else begin
            state_d = S_ACCUM;
          end
        end
        S_OUT: begin
          if (take_s) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            data_d  = {PROD_W{1'b0}};
            flag_d  = 1'b0;
            raw_d   = {ACC_W{1'b0}};
          end else begin
            state_d = S_OUT;
          end
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          data_d  = {PROD_W{1'b0}};
          flag_d  = 1'b0;
          raw_d   = {ACC_W{1'b0}};
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= {ACC_W{1'b0}};
      cnt_q   <= {LEN_W{1'b0}};
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= {PROD_W{1'b0}};
      flag_q  <= 1'b0;
      raw_q   <= {ACC_W{1'b0}};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      raw_q   <= raw_d;
    end
  end

endmodule
